xvc_jtag_shifter: RTL and testbench
===================================

# xvc_jtag_shifter

Executes the bit-level part of an XVC `shift:` command. The command engine in the microserver hands it one word of up to 32 TMS/TDI bit pairs. The block clocks them out on the physical JTAG pins at a divided TCK rate, captures TDO for every bit, and returns the TDO word through a response handshake. It sits directly downstream of the microserver's main command-processing core and directly drives the board JTAG header.

## Interface
- `CLK_DIV`, default 4: TCK half-period in `clock` cycles. Legal range 2..255.
- `clock` in 1: system clock. All logic is on the rising edge.
- `reset_n` in 1: asynchronous reset, active-low.
- `cmd_valid` in 1: command word valid.
- `cmd_ready` out 1: block can accept a command.
- `cmd_len` in 6: number of bits to shift. 0 means no shift; 33..63 are clamped to 32.
- `cmd_tms` in 32: TMS bits, LSB shifted first.
- `cmd_tdi` in 32: TDI bits, LSB shifted first.
- `rsp_valid` out 1: TDO word valid.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_tdo` out 32: captured TDO. Bit i is the sample for shifted bit i; bits at index >= len are 0.
- `busy` out 1: high in any state other than IDLE.
- `jtag_tck` out 1: JTAG clock.
- `jtag_tms` out 1: JTAG TMS.
- `jtag_tdi` out 1: JTAG TDI.
- `jtag_tdo` in 1: JTAG TDO. Asynchronous to `clock`.

## Operation
- **States:** IDLE, LOW, HIGH, RESP.
- **IDLE:**
  - `cmd_ready`=1.
  - On `cmd_valid & cmd_ready`, latch `cmd_tms`, `cmd_tdi` and clamped len, and clear the bit index and TDO accumulator.
  - If len=0, go to RESP. Otherwise go to LOW.
- **LOW:**
  - `jtag_tck`=0.
  - `jtag_tms`/`jtag_tdi` are driven with bit[index] from the first cycle of LOW.
  - Stay CLK_DIV cycles, then go to HIGH.
- **HIGH:**
  - `jtag_tck`=1 for CLK_DIV cycles.
  - On the last HIGH cycle, write `tdo_sync` into accumulator[index].
  - If index = len-1, go to RESP. Otherwise increment index and go to LOW.
- **RESP:**
  - `rsp_valid`=1, `jtag_tck`=0, `cmd_ready`=0.
  - On `rsp_ready`, go to IDLE.
  - `rsp_valid` and `rsp_tdo` are stable until accepted.
- **TDO synchronization:** `jtag_tdo` passes through a two-flop synchronizer; `tdo_sync` is the second flop. The TCK high phase of at least 2 cycles guarantees a target output launched on the falling edge has settled.
- **Pin outputs:**
  - All JTAG outputs are registered.
  - `jtag_tms`/`jtag_tdi` keep the last shifted value after completion. The TAP must remain in its final state.
- **Counters:**
  - Index is 5 bits.
  - Half-period counter is 8 bits and reloads on every phase change.
  - No wrap-around is possible because len <= 32.
- **Reset (`reset_n`=0, any state):**
  - State goes to IDLE.
  - `jtag_tck`=0, `jtag_tms`=1, `jtag_tdi`=0.
  - `rsp_valid`=0, `rsp_tdo`=0, `busy`=0, `cmd_ready`=1, counters 0.
  - A command in flight is dropped silently and no response is produced.
- **Simultaneous events:**
  - No new command is accepted during RESP, even in the cycle `rsp_ready` is high.
  - `cmd_ready` rises the cycle after the response handshake.

## Timing
- Let D = CLK_DIV and n = clamped len >= 1. Cycle 0 is the command handshake.
  - Cycles 1..D: bit0 on TMS/TDI, TCK low.
  - Cycles D+1..2D: TCK high; TDO sample taken at the end of cycle 2D.
  - Bit k occupies cycles 2Dk+1 .. 2D(k+1).
  - `rsp_valid` is high from cycle 2Dn+1.
- Command-to-response latency is 2·D·n+1 cycles, or 1 cycle for len=0.
- TCK period is 2D cycles with 50% duty cycle. There are exactly n rising edges per command.
- TMS/TDI change only on TCK falling edges or at LOW entry, so they get D cycles of setup before the rising edge.
- Minimum command throughput is one command per 2Dn+2 cycles (single response slot).

## Test plan
- D=2, len=1, tms=1, tdi=0:
  - exactly one TCK pulse, high in cycles 3-4;
  - `rsp_valid` at cycle 5;
  - `rsp_tdo`=0x00000000 with TDO tied 0.
- D=2, len=32, TDO looped from TDI, tdi=0xA5C30F81:
  - 32 TCK pulses;
  - `rsp_valid` at cycle 129;
  - `rsp_tdo`=0xA5C30F81.
- len=8, TDO tied 1 → `rsp_tdo`=0x000000FF. len=40 → clamped: 32 pulses, `rsp_tdo`=0xFFFFFFFF.
- len=0 → `rsp_valid` at cycle 1, `rsp_tdo`=0, no TCK edges, TMS/TDI unchanged.
- `rsp_ready` held low 10 cycles after completion:
  - `rsp_valid`/`rsp_tdo` stable;
  - `cmd_ready`=0;
  - TCK=0;
  - a second `cmd_valid` is ignored until the handshake, then accepted the following cycle.
- `reset_n` pulsed low during bit 5 HIGH phase:
  - immediately TCK=0, TMS=1, TDI=0, `busy`=0;
  - `cmd_ready`=1 after release;
  - no `rsp_valid` ever asserted for the aborted command.

Source files
------------

// File: rtl/xvc_jtag_shifter.sv
// rtl/xvc_jtag_shifter.sv - XVC shift engine: clocks up to 32 TMS/TDI bits out on JTAG, returns TDO word
//
// Purpose: takes one command word of up to 32 TMS/TDI bit pairs and shifts them
// LSB first at a TCK half-period of CLK_DIV clock cycles. TDO is sampled at the
// end of every TCK high phase and returned through a response handshake.
//
// Ports:
//   clock, reset_n             system clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_len (0..63, >32 clamps to 32),
//                              cmd_tms/cmd_tdi bit vectors
//   rsp_valid/rsp_ready        response handshake; rsp_tdo captured TDO bits
//   busy                       high whenever not idle
//   jtag_tck/tms/tdi           registered JTAG pin outputs
//   jtag_tdo                   JTAG TDO, asynchronous to clock
module xvc_jtag_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_len,
  input  logic [31:0] cmd_tms,
  input  logic [31:0] cmd_tdi,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_tdo,
  output logic        busy,
  output logic        jtag_tck,
  output logic        jtag_tms,
  output logic        jtag_tdi,
  input  logic        jtag_tdo
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} state_t;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [4:0]  idx_q;
  logic [5:0]  len_q;
  logic [31:0] tms_q, tdi_q, acc_q;
  logic        tck_q, tms_pin_q, tdi_pin_q;
  logic        tdo_s1_q, tdo_s2_q;

  logic [5:0]  len_clamp;
  logic        phase_done;
  logic        last_bit;

  assign len_clamp  = (cmd_len > 6'd32) ? 6'd32 : cmd_len;
  assign phase_done = (cnt_q == 8'd0);
  assign last_bit   = ({1'b0, idx_q} == (len_q - 6'd1));

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_valid) state_d = (len_clamp == 6'd0) ? RESP : LOW;
      LOW:  if (phase_done) state_d = HIGH;
      HIGH: if (phase_done) state_d = last_bit ? RESP : LOW;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state register only
  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    rsp_valid = (state_q == RESP);
  end

  assign rsp_tdo  = acc_q;
  assign jtag_tck = tck_q;
  assign jtag_tms = tms_pin_q;
  assign jtag_tdi = tdi_pin_q;

  // Two-flop TDO synchronizer; tdo_s2_q is the only copy the datapath reads
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tdo_s1_q <= 1'b0;
      tdo_s2_q <= 1'b0;
    end else begin
      tdo_s1_q <= jtag_tdo;
      tdo_s2_q <= tdo_s1_q;
    end
  end

  // Datapath: pins are updated on the same edge as the phase change so TMS/TDI
  // move together with the TCK falling edge and get a full low phase of setup.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= 8'd0;
      idx_q     <= 5'd0;
      len_q     <= 6'd0;
      tms_q     <= 32'd0;
      tdi_q     <= 32'd0;
      acc_q     <= 32'd0;
      tck_q     <= 1'b0;
      tms_pin_q <= 1'b1;
      tdi_pin_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            tms_q <= cmd_tms;
            tdi_q <= cmd_tdi;
            len_q <= len_clamp;
            idx_q <= 5'd0;
            acc_q <= 32'd0;
            cnt_q <= DIV_M1;
            // A zero-length command leaves the TAP pins untouched
            if (len_clamp != 6'd0) begin
              tms_pin_q <= cmd_tms[0];
              tdi_pin_q <= cmd_tdi[0];
            end
          end
        end
        LOW: begin
          if (phase_done) begin
            tck_q <= 1'b1;
            cnt_q <= DIV_M1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        HIGH: begin
          if (phase_done) begin
            acc_q[idx_q] <= tdo_s2_q;
            tck_q        <= 1'b0;
            cnt_q        <= DIV_M1;
            // On the last bit the pins keep their value so the TAP stays put
            if (!last_bit) begin
              idx_q     <= idx_q + 5'd1;
              tms_pin_q <= tms_q[idx_q + 5'd1];
              tdi_pin_q <= tdi_q[idx_q + 5'd1];
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xvc_jtag_shifter.sv
// tb/tb_xvc_jtag_shifter.sv - self-checking bench for xvc_jtag_shifter
module tb_xvc_jtag_shifter;

  localparam int D = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_len = 6'd0;
  logic [31:0] cmd_tms = 32'd0;
  logic [31:0] cmd_tdi = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_tdo;
  logic        busy;
  logic        jtag_tck, jtag_tms, jtag_tdi;
  logic        jtag_tdo;

  // TDO source: 0 tied low, 1 tied high, 2 looped back from TDI
  int mode = 0;
  assign jtag_tdo = (mode == 2) ? jtag_tdi : (mode == 1);

  int checks = 0;
  int errors = 0;
  logic pin_tms = 1'b1;
  logic pin_tdi = 1'b0;

  xvc_jtag_shifter #(.CLK_DIV(D)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_tms(cmd_tms), .cmd_tdi(cmd_tdi),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tdo(rsp_tdo),
    .busy(busy), .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
    .jtag_tdo(jtag_tdo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp_len(input logic [5:0] len);
    return (len > 6'd32) ? 32 : int'(len);
  endfunction

  function automatic logic [31:0] model_tdo(input logic [5:0] len, input logic [31:0] tdi, input int m);
    int n;
    logic [31:0] mask;
    n = clamp_len(len);
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    if (m == 0) return 32'd0;
    if (m == 1) return mask;
    return tdi & mask;
  endfunction

  task automatic drive_cmd(input logic [5:0] len, input logic [31:0] tms, input logic [31:0] tdi);
    cmd_valid = 1'b1;
    cmd_len   = len;
    cmd_tms   = tms;
    cmd_tdi   = tdi;
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 into cycle 1
  task automatic start_cmd(input logic [5:0] len, input logic [31:0] tms, input logic [31:0] tdi);
    drive_cmd(len, tms, tdi);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  // Walks cycles 1.. checking the TCK waveform and the bit on TMS/TDI for each cycle
  task automatic wait_rsp(input logic [5:0] len, input logic [31:0] tms, input logic [31:0] tdi);
    int n, c, k, lat;
    n = clamp_len(len);
    lat = (n == 0) ? 1 : 2 * D * n + 1;
    for (c = 1; c <= 400; c++) begin
      if (rsp_valid) break;
      k = (c - 1) / (2 * D);
      chk("tck_wave", 32'(jtag_tck), 32'(((c - 1) % (2 * D)) >= D));
      if (k < 32) begin
        chk("tms_bit", 32'(jtag_tms), 32'(tms[k]));
        chk("tdi_bit", 32'(jtag_tdi), 32'(tdi[k]));
      end
      @(posedge clock); #1;
    end
    chk("latency", 32'(c), 32'(lat));
    chk("rsp_tdo", rsp_tdo, model_tdo(len, tdi, mode));
    if (n > 0) begin
      pin_tms = tms[n - 1];
      pin_tdi = tdi[n - 1];
    end
  endtask

  task automatic finish_rsp(input int hold, input logic [31:0] exp_tdo);
    repeat (hold) begin
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_tdo", rsp_tdo, exp_tdo);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("hold_tck", 32'(jtag_tck), 32'd0);
      chk("hold_tms", 32'(jtag_tms), 32'(pin_tms));
      chk("hold_tdi", 32'(jtag_tdi), 32'(pin_tdi));
      @(posedge clock); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  task automatic run(input logic [5:0] len, input logic [31:0] tms, input logic [31:0] tdi, input int hold);
    start_cmd(len, tms, tdi);
    wait_rsp(len, tms, tdi);
    finish_rsp(hold, model_tdo(len, tdi, mode));
  endtask

  initial begin
    logic [5:0]  rl;
    logic [31:0] rt, rd;
    bit          saw_rsp;

    // Reset state
    @(posedge clock); #1;
    chk("rst_tck", 32'(jtag_tck), 32'd0);
    chk("rst_tms", 32'(jtag_tms), 32'd1);
    chk("rst_tdi", 32'(jtag_tdi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_tdo", rsp_tdo, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Single bit, TDO low
    mode = 0;
    run(6'd1, 32'h1, 32'h0, 0);

    // Full 32 bits with TDO looped back from TDI
    mode = 2;
    run(6'd32, $urandom, 32'hA5C3_0F81, 1);

    // TDO high, len 8 and a clamped len 40
    mode = 1;
    run(6'd8, $urandom, $urandom, 0);
    run(6'd40, $urandom, $urandom, 0);

    // Zero length: immediate response, pins unchanged
    run(6'd0, $urandom, $urandom, 2);

    // Response stall with a second command waiting
    mode = 2;
    rt = $urandom; rd = $urandom;
    start_cmd(6'd5, rt, rd);
    wait_rsp(6'd5, rt, rd);
    drive_cmd(6'd3, 32'h5, 32'h6);
    finish_rsp(10, model_tdo(6'd5, rd, mode));
    chk("second_not_yet", 32'(busy), 32'd0);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    chk("second_accepted", 32'(busy), 32'd1);
    wait_rsp(6'd3, 32'h5, 32'h6);
    finish_rsp(0, model_tdo(6'd3, 32'h6, mode));

    // Randomized commands
    for (int i = 0; i < 8; i++) begin
      mode = int'($urandom_range(0, 2));
      rl = 6'($urandom_range(0, 40));
      rt = $urandom;
      rd = $urandom;
      run(rl, rt, rd, int'($urandom_range(0, 3)));
    end

    // Reset during the high phase of bit 5
    mode = 1;
    start_cmd(6'd10, $urandom, $urandom);
    repeat (22) @(posedge clock);
    #1;
    chk("abort_in_high", 32'(jtag_tck), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_tck", 32'(jtag_tck), 32'd0);
    chk("abort_tms", 32'(jtag_tms), 32'd1);
    chk("abort_tdi", 32'(jtag_tdi), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    pin_tms = 1'b1;
    pin_tdi = 1'b0;
    @(posedge clock); #1;
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    saw_rsp = 1'b0;
    repeat (100) begin
      if (rsp_valid) saw_rsp = 1'b1;
      @(posedge clock); #1;
    end
    chk("abort_no_rsp", 32'(saw_rsp), 32'd0);

    // Normal operation after the abort
    mode = 2;
    run(6'd7, $urandom, $urandom, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
